// File: rtl/ledger_pkg.sv
// Shared types and geometry for the ledger-line pixel stage.
// is_ledger decides whether staff line `lidx` needs a ledger for a note at step `pos`.
package ledger_pkg;

    typedef enum logic [1:0] {
        BLANK  = 2'b00,
        MIDDLE = 2'b01,
        ABOVE  = 2'b10,
        BELOW  = 2'b11
    } ledger_code_t;

    localparam int CELL_PX        = 8;
    localparam int CELL_ROWS      = 16;
    localparam int STAFF_TOP_LINE = 4;
    localparam int LINE_ROW0      = 7;

    // Steps are half-lines, so compare in doubled line units with one guard bit.
    function automatic logic is_ledger(input logic signed [4:0] lidx,
                                       input logic signed [4:0] pos);
        logic signed [5:0] two_l;
        logic signed [5:0] pos6;
        two_l = {lidx, 1'b0};
        pos6  = {pos[4], pos};
        is_ledger = (lidx[4] && (two_l >= pos6)) ||
                    ((lidx > 5'(STAFF_TOP_LINE)) && (two_l <= pos6));
    endfunction

endpackage

// File: rtl/ledger_slot_table.sv
// Per-slot note registers with a write port, combinational read port and a one-slot-per-cycle clear sweep.
// Writes land next cycle; wr_rdy_o is low for exactly NUM_SLOTS cycles while sweeping.
module ledger_slot_table #(
    parameter int NUM_SLOTS = 32,
    localparam int SW = $clog2(NUM_SLOTS)
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          wr_vld_i,
    output logic          wr_rdy_o,
    input  logic [SW-1:0] wr_slot_i,
    input  logic          wr_en_i,
    input  logic [4:0]    wr_pos_i,
    input  logic          clear_i,
    input  logic [SW-1:0] rd_slot_i,
    output logic          rd_occ_o,
    output logic [4:0]    rd_pos_o
);
    import ledger_pkg::*;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    logic [0:0]           state_q, state_d;
    logic [SW-1:0]        cnt_q, cnt_d;
    logic [NUM_SLOTS-1:0] occ_q, occ_d;
    logic [4:0]           pos_q [NUM_SLOTS];
    logic                 wr_fire;

    assign wr_rdy_o = (state_q == ST_IDLE);
    assign wr_fire  = wr_vld_i && wr_rdy_o;
    assign rd_occ_o = occ_q[rd_slot_i];
    assign rd_pos_o = pos_q[rd_slot_i];

    // A write accepted alongside clear_i still lands; the sweep then erases it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        occ_d   = occ_q;
        if (state_q == ST_IDLE) begin
            if (wr_fire) occ_d[wr_slot_i] = wr_en_i;
            if (clear_i) begin
                state_d = ST_CLEAR;
                cnt_d   = '0;
            end
        end else begin
            occ_d[cnt_q] = 1'b0;
            cnt_d        = cnt_q + 1'b1;
            if (cnt_q == SW'(NUM_SLOTS - 1)) state_d = ST_IDLE;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            occ_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            occ_q   <= occ_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (wr_fire) pos_q[wr_slot_i] <= wr_pos_i;
    end

endmodule

// File: rtl/ledger_line_gen.sv
// Three-stage pixel pipeline: window/cell decode, slot lookup to ROM address, ROM row bit select.
// rom_addr two cycles and ledger_on three cycles after pixel_valid; never stalls.
module ledger_line_gen #(
    parameter int X_ORIGIN  = 64,
    parameter int Y_ORIGIN  = 112,
    parameter int NUM_SLOTS = 32
) (
    input  logic                         Clk,
    input  logic                         Reset_n,
    input  logic                         pixel_valid,
    input  logic [9:0]                   DrawX,
    input  logic [9:0]                   DrawY,
    input  logic                         note_valid,
    output logic                         note_ready,
    input  logic [$clog2(NUM_SLOTS)-1:0] note_slot,
    input  logic                         note_en,
    input  logic [4:0]                   note_pos,
    input  logic                         clear_all,
    output logic [4:0]                   rom_addr,
    input  logic [7:0]                   rom_data,
    output logic                         ledger_valid,
    output logic                         ledger_on
);
    import ledger_pkg::*;

    localparam int SW = $clog2(NUM_SLOTS);

    logic signed [10:0] dx, dy;
    logic               p1_win_d;
    logic signed [4:0]  p1_l_d;

    logic               p1_vld_q, p1_win_q;
    logic [SW-1:0]      p1_slot_q;
    logic [2:0]         p1_c_q, p1_r_q;
    logic signed [4:0]  p1_l_q;

    logic               rd_occ;
    logic [4:0]         rd_pos;
    ledger_code_t       code_d;

    logic               p2_vld_q, p2_win_q;
    logic [2:0]         p2_c_q;
    logic [4:0]         rom_addr_q;
    logic               ledger_on_q, ledger_valid_q;

    assign dx       = {1'b0, DrawX} - 11'(X_ORIGIN);
    assign dy       = {1'b0, DrawY} - 11'(Y_ORIGIN);
    assign p1_win_d = !dx[10] && (dx < 11'(CELL_PX * NUM_SLOTS)) &&
                      !dy[10] && (dy < 11'(CELL_PX * CELL_ROWS));
    // Cell row 0 is the topmost line of the grid, so line index counts down.
    assign p1_l_d   = 5'(LINE_ROW0) - {1'b0, dy[6:3]};

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            p1_vld_q  <= 1'b0;
            p1_win_q  <= 1'b0;
            p1_slot_q <= '0;
            p1_c_q    <= '0;
            p1_r_q    <= '0;
            p1_l_q    <= '0;
        end else begin
            p1_vld_q <= pixel_valid;
            if (pixel_valid) begin
                p1_win_q  <= p1_win_d;
                p1_slot_q <= dx[SW+2:3];
                p1_c_q    <= dx[2:0];
                p1_r_q    <= dy[2:0];
                p1_l_q    <= p1_l_d;
            end
        end
    end

    ledger_slot_table #(.NUM_SLOTS(NUM_SLOTS)) u_table (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .wr_vld_i  (note_valid),
        .wr_rdy_o  (note_ready),
        .wr_slot_i (note_slot),
        .wr_en_i   (note_en),
        .wr_pos_i  (note_pos),
        .clear_i   (clear_all),
        .rd_slot_i (p1_slot_q),
        .rd_occ_o  (rd_occ),
        .rd_pos_o  (rd_pos)
    );

    assign code_d = (p1_win_q && rd_occ && is_ledger(p1_l_q, rd_pos)) ? MIDDLE : BLANK;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            p2_vld_q       <= 1'b0;
            p2_win_q       <= 1'b0;
            p2_c_q         <= '0;
            rom_addr_q     <= '0;
            ledger_on_q    <= 1'b0;
            ledger_valid_q <= 1'b0;
        end else begin
            p2_vld_q <= p1_vld_q;
            if (p1_vld_q) begin
                p2_win_q   <= p1_win_q;
                p2_c_q     <= p1_c_q;
                rom_addr_q <= {code_d, p1_r_q};
            end
            ledger_valid_q <= p2_vld_q;
            ledger_on_q    <= p2_vld_q && p2_win_q && rom_data[3'd7 - p2_c_q];
        end
    end

    assign rom_addr     = rom_addr_q;
    assign ledger_on    = ledger_on_q;
    assign ledger_valid = ledger_valid_q;

endmodule
